// File: rtl/inst_fetch_stage.sv
// IF stage: owns the PC, drives the instruction ROM address/enable, registers the fetched word into IF/ID.
// Latency: one edge from PC on rom_addr_o to instruction on id_*; a redirect in cycle N is on rom_addr_o after edge N.
// Backpressure: if_stall_i holds the PC (a branch arriving meanwhile is parked), id_stall_i holds IF/ID.
// Build option: define IF_DELAY_SLOT_EN for MIPS delay-slot behaviour; leave it undefined to squash
// the sequential instruction that was in IF when a taken redirect is applied.
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall_i,
  input  logic        id_stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  typedef enum logic {
    FS_RESET = 1'b0,
    FS_RUN   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } ifid_t;

`ifdef IF_DELAY_SLOT_EN
  localparam bit SQUASH_SLOT = 1'b0;
`else
  localparam bit SQUASH_SLOT = 1'b1;
`endif

  localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, inst: 32'h0, valid: 1'b0};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pending_q, pending_d;
  logic [31:0]  ptarget_q, ptarget_d;
  ifid_t        ifid_q, ifid_d;

  logic         fetch_en;
  logic         stall_if;
  logic         redirect_taken;

  // The illegal pattern (IF/ID held but IF running) is folded into a full stall.
  assign stall_if = if_stall_i | id_stall_i;
  assign fetch_en = (state_q == FS_RUN);

  // Fetch-enable state register: leaves FS_RESET on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next fetch state: one idle cycle after reset, then fetch forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_RESET: state_d = FS_RUN;
      FS_RUN:   state_d = FS_RUN;
      default:  state_d = FS_RESET;
    endcase
  end

  // Next-PC selection: flush, stall (parks a branch), live branch, parked branch, sequential.
  always_comb begin
    pc_d           = pc_q;
    pending_d      = pending_q;
    ptarget_d      = ptarget_q;
    redirect_taken = 1'b0;
    if (fetch_en) begin
      if (flush_i) begin
        pc_d      = flush_pc_i;
        pending_d = 1'b0;
      end else if (stall_if) begin
        if (branch_flag_i) begin
          pending_d = 1'b1;
          ptarget_d = branch_target_i;
        end
      end else if (branch_flag_i) begin
        pc_d           = branch_target_i;
        pending_d      = 1'b0;
        redirect_taken = 1'b1;
      end else if (pending_q) begin
        pc_d           = ptarget_q;
        pending_d      = 1'b0;
        redirect_taken = 1'b1;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  // PC and parked-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      ptarget_q <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      ptarget_q <= ptarget_d;
    end
  end

  // IF/ID next value: flush and IF-only stall insert bubbles, ID stall holds,
  // and without delay slots the word fetched alongside a taken redirect is dropped.
  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d = IFID_BUBBLE;
    end else if (id_stall_i) begin
      ifid_d = ifid_q;
    end else if (stall_if) begin
      ifid_d = IFID_BUBBLE;
    end else if (SQUASH_SLOT && redirect_taken) begin
      ifid_d = IFID_BUBBLE;
    end else begin
      ifid_d.pc    = pc_q;
      ifid_d.inst  = rom_data_i;
      ifid_d.valid = fetch_en;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= IFID_BUBBLE;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = fetch_en;
  assign id_pc_o    = ifid_q.pc;
  assign id_inst_o  = ifid_q.inst;
  assign id_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios then random traffic with async resets.
// Outputs are compared at the falling edge against a transaction-level reference model.
// The ROM is modelled as a pure function of the address.
module tb_inst_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_stall_i, id_stall_i, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, flush_pc_i, rom_data_i;
  logic [31:0] rom_addr_o, id_pc_o, id_inst_o;
  logic        rom_ce_o, id_valid_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_stall_i      (if_stall_i),
    .id_stall_i      (id_stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .rom_data_i      (rom_data_i),
    .rom_addr_o      (rom_addr_o),
    .rom_ce_o        (rom_ce_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .id_valid_o      (id_valid_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3401_8000;
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  // ---------------- reference model ----------------
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] park_q[$];
  logic [31:0] m_id_pc, m_id_inst;
  logic        m_id_valid;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  task automatic model_reset();
    m_run = 0;
    m_pc  = 32'h0;
    park_q.delete();
    m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
  endtask

  // One rising edge of the stage, applied to the inputs currently driven.
  task automatic model_edge();
    bit frozen_if, squash, bubble, hold;
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    frozen_if  = if_stall_i || id_stall_i;
    squash     = 0;
    if (m_run) begin
      if (flush_i) begin
        m_pc = flush_pc_i;
        park_q.delete();
      end else if (frozen_if) begin
        if (branch_flag_i) begin
          park_q.delete();
          park_q.push_back(branch_target_i);
        end
      end else if (branch_flag_i) begin
        m_pc = branch_target_i;
        park_q.delete();
        squash = !DELAY_SLOT;
      end else if (park_q.size() != 0) begin
        m_pc = park_q.pop_front();
        squash = !DELAY_SLOT;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    hold   = !flush_i && id_stall_i;
    bubble = flush_i || (!hold && (frozen_if || squash));
    if (bubble) begin
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    end else if (!hold) begin
      m_id_pc = fetched_pc; m_id_inst = rom_word(fetched_pc); m_id_valid = m_run;
    end
    m_run = 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rom_ce",   {31'h0, rom_ce_o},   {31'h0, m_run});
    chk("rom_addr", rom_addr_o,          m_pc);
    chk("id_pc",    id_pc_o,             m_id_pc);
    chk("id_inst",  id_inst_o,           m_id_inst);
    chk("id_valid", {31'h0, id_valid_o}, {31'h0, m_id_valid});
  endtask

  // Drive one cycle of inputs (called at a falling edge), clock it, check at the next falling edge.
  task automatic cyc(input logic is, input logic ds, input logic br, input logic [31:0] bt,
                     input logic fl, input logic [31:0] fp);
    if_stall_i = is; id_stall_i = ds; branch_flag_i = br; branch_target_i = bt;
    flush_i = fl; flush_pc_i = fp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    if_stall_i = 0; id_stall_i = 0; branch_flag_i = 0; flush_i = 0;
    branch_target_i = 0; flush_pc_i = 0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;

    // Reset release: enable after edge 1, first instruction after edge 2.
    cyc(0, 0, 0, 0, 0, 0);
    chk("rel_ce", {31'h0, rom_ce_o}, 32'h1);
    chk("rel_addr0", rom_addr_o, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rel_inst", id_inst_o, 32'h3401_8000);
    chk("rel_valid", {31'h0, id_valid_o}, 32'h1);
    chk("rel_addr4", rom_addr_o, 32'h4);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("pre_br_addr", rom_addr_o, 32'h10);

    // Taken branch from 0x10 to 0x20.
    cyc(0, 0, 1, 32'h20, 0, 0);
    chk("br_addr", rom_addr_o, 32'h20);
`ifdef IF_DELAY_SLOT_EN
    chk("br_slot_pc", id_pc_o, 32'h10);
    chk("br_slot_valid", {31'h0, id_valid_o}, 32'h1);
`else
    chk("br_squash_valid", {31'h0, id_valid_o}, 32'h0);
`endif

    // Get to 0x18 then stall both stages for two cycles.
    cyc(0, 0, 0, 0, 1, 32'h14);
    cyc(0, 0, 0, 0, 0, 0);
    chk("st_addr", rom_addr_o, 32'h18);
    repeat (2) begin
      cyc(1, 1, 0, 0, 0, 0);
      chk("st_hold_addr", rom_addr_o, 32'h18);
      chk("st_hold_pc", id_pc_o, 32'h14);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("ifst_addr", rom_addr_o, 32'h18);
    chk("ifst_valid", {31'h0, id_valid_o}, 32'h0);

    // Branch parked during a 3-cycle IF stall.
    cyc(1, 0, 1, 32'h4C, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pend_held", rom_addr_o, 32'h18);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pend_addr", rom_addr_o, 32'h4C);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pend_next", rom_addr_o, 32'h50);

    // Flush beats stall, live branch and a parked branch.
    cyc(1, 0, 1, 32'h90, 0, 0);
    cyc(1, 0, 1, 32'hA0, 1, 32'h60);
    chk("fl_addr", rom_addr_o, 32'h60);
    chk("fl_valid", {31'h0, id_valid_o}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("fl_no_pend", rom_addr_o, 32'h64);

    // PC wrap.
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_addr", rom_addr_o, 32'h0);
    chk("wrap_id_pc", id_pc_o, 32'hFFFF_FFFC);

    // Async reset pulse between edges.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst2_addr", rom_addr_o, 32'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] bt;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, bt,
          $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
